tape_ram_arbiter: RTL and testbench

Shares the single system-RAM write port between the CPU and the TAP loader's byte stream. Loader bytes are buffered in a small FIFO and retired only in non-CPU cycles. After a BASIC load, the block patches the ROM's program/variable pointers and optionally raises an autorun request. It sits between the cassette loader, the 6502 bus and the RAM macro, and holds the CPU while a load is in progress.

---
 rtl/oric_pkg.sv | 31 +++
 rtl/tape_ram_arbiter_if.sv | 45 ++++
 rtl/tape_ram_arbiter_byte_fifo.sv | 64 ++++++
 rtl/tape_ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tape_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oric_pkg.sv
// -----------------------------------------------------------------------------
// oric_pkg
// Shared definitions for the tape loader / RAM arbiter slice:
//   - arb_state_t : arbiter FSM states
//   - ld_byte_t   : one buffered loader byte (address + data)
//   - TAP header constants and the default BASIC pointer base address
// -----------------------------------------------------------------------------
package oric_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_PATCH,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } ld_byte_t;

    // TAP header file-type and autorun codes
    localparam logic [7:0] TAP_TYPE_BASIC = 8'h00;
    localparam logic [7:0] TAP_TYPE_MC    = 8'h80;
    localparam logic [7:0] TAP_AUTORUN    = 8'hC7;

    // First ROM BASIC pointer byte (program/variable pointers follow)
    localparam logic [15:0] PTR_BASE_DEFAULT = 16'h009C;

endpackage

// File: rtl/tape_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// tape_ram_arbiter_if
// Bundles the loader byte stream, the CPU write bus and the RAM write port.
//   master : drives loader/CPU signals, observes RAM port and status
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface tape_ram_arbiter_if;

    // Cassette loader
    logic        ld_active;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_dout;
    logic [15:0] ld_end_addr;
    logic        ld_basic;
    logic        ld_autorun;
    logic        autostart_basic;

    // 6502 bus
    logic        cpu_slot;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;

    // RAM write port and status
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        cpu_hold;
    logic        autorun_req;
    logic        overflow;

    modport master (
        output ld_active, ld_wr, ld_addr, ld_dout, ld_end_addr, ld_basic,
               ld_autorun, autostart_basic, cpu_slot, cpu_we, cpu_addr, cpu_dout,
        input  ram_we, ram_addr, ram_din, cpu_hold, autorun_req, overflow
    );

    modport slave (
        input  ld_active, ld_wr, ld_addr, ld_dout, ld_end_addr, ld_basic,
               ld_autorun, autostart_basic, cpu_slot, cpu_we, cpu_addr, cpu_dout,
        output ram_we, ram_addr, ram_din, cpu_hold, autorun_req, overflow
    );

endinterface

// File: rtl/tape_ram_arbiter_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO with first-word-fall-through read.
//   clk, reset_n : clock, synchronous active-low reset
//   clear_i      : empty the FIFO (same effect as reset on the pointers)
//   push_i/din_i : write request and data; accepted when not full, or when
//                  a pop happens in the same cycle
//   pop_i        : remove head entry; ignored when empty
//   dout_o       : current head entry
//   full_o/empty_o
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define validity,
    // and leaving the array reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tape_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tape_ram_arbiter
// Shares the RAM write port between the CPU and the TAP loader. Loader bytes
// are buffered and written only in non-CPU cycles; after a BASIC load the ROM
// program/variable pointers are patched with the end address and an autorun
// pulse may be raised. The CPU is held while any of this is in progress.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : loader inputs, CPU bus inputs, registered RAM port,
//                  cpu_hold, autorun_req pulse, sticky overflow
// -----------------------------------------------------------------------------
module tape_ram_arbiter
    import oric_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PTR_BASE   = PTR_BASE_DEFAULT,
    parameter int          PTR_COUNT  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tape_ram_arbiter_if.slave    bus
);

    localparam logic [2:0] K_LAST = 3'(2 * PTR_COUNT - 1);

    arb_state_t  state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] end_addr_q, end_addr_d;
    logic        basic_q, basic_d;
    logic        autorun_q, autorun_d;
    logic        ram_we_q, ram_we_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        autorun_req_q, autorun_req_d;
    logic        overflow_q, overflow_d;

    logic        in_load, push_req;
    logic        fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
    ld_byte_t    fifo_din, fifo_dout;

    assign fifo_din = '{addr: bus.ld_addr, data: bus.ld_dout};

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ld_byte_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        end_addr_d    = end_addr_q;
        basic_d       = basic_q;
        autorun_d     = autorun_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        overflow_d    = overflow_q;
        fifo_clear    = 1'b0;

        in_load   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
        push_req  = in_load && bus.ld_wr;
        fifo_pop  = in_load && !bus.cpu_slot && !fifo_empty;
        // A pop frees the slot this cycle, so a full FIFO still accepts the push.
        fifo_push = push_req && (!fifo_full || fifo_pop);
        if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;

        // RAM port: CPU first, then buffered loader bytes, then pointer patching.
        if (bus.cpu_slot) begin
            ram_we_d   = bus.cpu_we;
            ram_addr_d = bus.cpu_addr;
            ram_din_d  = bus.cpu_dout;
        end else if (fifo_pop) begin
            ram_we_d   = 1'b1;
            ram_addr_d = fifo_dout.addr;
            ram_din_d  = fifo_dout.data;
        end else if (state_q == ST_PATCH) begin
            ram_we_d   = 1'b1;
            ram_addr_d = PTR_BASE + {13'd0, k_q};
            ram_din_d  = k_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
            if (k_q == K_LAST) begin
                k_d     = 3'd0;
                state_d = ST_DONE;
            end else begin
                k_d = k_q + 3'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.ld_active) begin
                    state_d    = ST_LOAD;
                    overflow_d = 1'b0;
                    fifo_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!bus.ld_active) begin
                    state_d    = ST_DRAIN;
                    end_addr_d = bus.ld_end_addr;
                    basic_d    = bus.ld_basic;
                    autorun_d  = bus.ld_autorun;
                end
            end
            ST_DRAIN: begin
                // A late byte entering an empty FIFO keeps us draining.
                if (fifo_empty && !fifo_push) state_d = basic_q ? ST_PATCH : ST_DONE;
            end
            ST_PATCH: ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cpu_hold_d    = (state_d != ST_IDLE);
        autorun_req_d = (state_d == ST_DONE) && autorun_q && bus.autostart_basic;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            k_q           <= 3'd0;
            end_addr_q    <= 16'd0;
            basic_q       <= 1'b0;
            autorun_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= 16'd0;
            ram_din_q     <= 8'd0;
            cpu_hold_q    <= 1'b0;
            autorun_req_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            end_addr_q    <= end_addr_d;
            basic_q       <= basic_d;
            autorun_q     <= autorun_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            cpu_hold_q    <= cpu_hold_d;
            autorun_req_q <= autorun_req_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.cpu_hold    = cpu_hold_q;
    assign bus.autorun_req = autorun_req_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tape_ram_arbiter
// Directed stimulus pushes every expected RAM write into exp_q; a monitor pops
// and compares each time ram_we is seen. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_tape_ram_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tape_ram_arbiter_if bus ();

    tape_ram_arbiter #(
        .FIFO_DEPTH (4),
        .PTR_BASE   (16'h009C),
        .PTR_COUNT  (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          autorun_cnt = 0;
    bit          armed = 1'b0;
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            if (bus.autorun_req) autorun_cnt++;
            if (bus.ram_we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h expected none",
                             bus.ram_addr, bus.ram_din);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ram_write", {8'h00, bus.ram_addr, bus.ram_din}, {8'h00, mon_e});
                end
            end
        end
    end

    function automatic logic [23:0] patch_exp(input int k, input logic [15:0] end_a);
        logic [15:0] a;
        a = 16'h009C + 16'(k);
        return {a, (k % 2 == 1) ? end_a[15:8] : end_a[7:0]};
    endfunction

    task automatic wait_hold_low(input string tag);
        int t;
        t = 0;
        while (bus.cpu_hold && t < 100) begin
            tick();
            t++;
        end
        check({tag, "_hold_release"}, {31'd0, bus.cpu_hold}, 32'd0);
        check({tag, "_all_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_load(input bit basic, input bit autorun, input bit autostart,
                            input int n, input logic [15:0] start, input logic [7:0] dseed,
                            input logic [15:0] end_a, input string tag);
        int base;
        logic [15:0] a;
        logic [7:0]  d;
        base = autorun_cnt;
        bus.autostart_basic = autostart;
        bus.ld_active = 1'b1;
        tick();
        check({tag, "_hold_start"}, {31'd0, bus.cpu_hold}, 32'd1);
        check({tag, "_ovf_start"}, {31'd0, bus.overflow}, 32'd0);
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            d = dseed + 8'(i);
            bus.ld_wr   = 1'b1;
            bus.ld_addr = a;
            bus.ld_dout = d;
            exp_q.push_back({a, d});
            tick();
        end
        bus.ld_wr       = 1'b0;
        bus.ld_active   = 1'b0;
        bus.ld_end_addr = end_a;
        bus.ld_basic    = basic;
        bus.ld_autorun  = autorun;
        tick();
        if (basic) begin
            for (int k = 0; k < 6; k++) exp_q.push_back(patch_exp(k, end_a));
        end
        wait_hold_low(tag);
        check({tag, "_autorun"}, autorun_cnt - base, (autorun && autostart) ? 32'd1 : 32'd0);
    endtask

    // Starts a one-byte BASIC load and returns in the first PATCH cycle (k=0).
    task automatic start_basic_1byte(input logic [15:0] a, input logic [7:0] d,
                                     input logic [15:0] end_a, input bit autorun);
        bus.ld_active = 1'b1;
        tick();
        bus.ld_wr   = 1'b1;
        bus.ld_addr = a;
        bus.ld_dout = d;
        exp_q.push_back({a, d});
        tick();
        bus.ld_wr       = 1'b0;
        bus.ld_active   = 1'b0;
        bus.ld_end_addr = end_a;
        bus.ld_basic    = 1'b1;
        bus.ld_autorun  = autorun;
        tick();     // pop of the byte, LOAD -> DRAIN
        tick();     // DRAIN empty -> PATCH
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] slot_ovf;
        logic [7:0] keep_ovf;
        logic [9:0] slot_pat;
        int k;
        int c;
        int base;

        bus.ld_active = 0; bus.ld_wr = 0; bus.ld_addr = 0; bus.ld_dout = 0;
        bus.ld_end_addr = 0; bus.ld_basic = 0; bus.ld_autorun = 0; bus.autostart_basic = 0;
        bus.cpu_slot = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_dout = 0;

        // Reset values
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_ram_we",   {31'd0, bus.ram_we}, 32'd0);
        check("rst_ram_addr", {16'd0, bus.ram_addr}, 32'd0);
        check("rst_ram_din",  {24'd0, bus.ram_din}, 32'd0);
        check("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("rst_autorun",  {31'd0, bus.autorun_req}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        reset_n = 1'b1;
        armed = 1'b1;
        tick();

        // ld_wr in IDLE is ignored
        bus.ld_wr = 1'b1; bus.ld_addr = 16'h4000; bus.ld_dout = 8'h55;
        tick(); tick(); tick();
        bus.ld_wr = 1'b0;
        tick(); tick();
        check("idle_wr_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("idle_wr_ovf",  {31'd0, bus.overflow}, 32'd0);

        // CPU write in IDLE passes through with one cycle latency
        bus.cpu_slot = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2345; bus.cpu_dout = 8'h9A;
        exp_q.push_back({16'h2345, 8'h9A});
        tick();
        bus.cpu_slot = 1'b0; bus.cpu_we = 1'b0;
        tick();
        check("cpu_idle_drained", exp_q.size(), 32'd0);

        // BASIC load with autorun enabled, then disabled
        run_load(1'b1, 1'b1, 1'b1, 3, 16'h0501, 8'h11, 16'h0504, "basic_ar");
        run_load(1'b1, 1'b1, 1'b0, 3, 16'h0501, 8'h11, 16'h0504, "basic_noar");

        // Overflow: 8 back-to-back bytes, CPU owns 6 of those cycles (free at 2 and 5).
        // Pops at cycles 2 and 5 let 4+2 bytes in; the bytes of cycles 6 and 7 are dropped.
        slot_ovf = 8'b1101_1011;
        keep_ovf = 8'b0011_1111;
        bus.ld_active = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.cpu_slot = slot_ovf[i];
            bus.cpu_we   = 1'b0;
            bus.ld_wr    = 1'b1;
            bus.ld_addr  = 16'h0800 + 16'(i);
            bus.ld_dout  = 8'hC0 + 8'(i);
            if (keep_ovf[i]) exp_q.push_back({16'h0800 + 16'(i), 8'hC0 + 8'(i)});
            tick();
        end
        check("ovf_set", {31'd0, bus.overflow}, 32'd1);
        bus.cpu_slot = 1'b0; bus.ld_wr = 1'b0; bus.ld_active = 1'b0;
        bus.ld_end_addr = 16'h0806; bus.ld_basic = 1'b0; bus.ld_autorun = 1'b0;
        tick();
        wait_hold_low("ovf");
        check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // MC load wrapping the address space; overflow clears at load start
        run_load(1'b0, 1'b0, 1'b1, 4, 16'hFFFE, 8'h60, 16'h0002, "mc_wrap");

        // CPU writes interleaved with pointer patching
        start_basic_1byte(16'h0700, 8'h77, 16'h1234, 1'b0);
        slot_pat = 10'b00_1001_1010;
        k = 0;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            if (slot_pat[i]) begin
                bus.cpu_slot = 1'b1; bus.cpu_we = 1'b1;
                bus.cpu_addr = 16'h3000 + 16'(c);
                bus.cpu_dout = 8'hA1 + 8'(c);
                exp_q.push_back({16'h3000 + 16'(c), 8'hA1 + 8'(c)});
                c++;
            end else begin
                bus.cpu_slot = 1'b0; bus.cpu_we = 1'b0;
                exp_q.push_back(patch_exp(k, 16'h1234));
                k++;
            end
            tick();
        end
        bus.cpu_slot = 1'b0; bus.cpu_we = 1'b0;
        wait_hold_low("patch_cpu");

        // Reset during PATCH with k=3: outputs return to reset values, no more writes
        base = autorun_cnt;
        start_basic_1byte(16'h0900, 8'h5A, 16'h0504, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(patch_exp(i, 16'h0504));
            tick();
        end
        reset_n = 1'b0;
        tick();
        check("mid_rst_ram_we",   {31'd0, bus.ram_we}, 32'd0);
        check("mid_rst_ram_addr", {16'd0, bus.ram_addr}, 32'd0);
        check("mid_rst_ram_din",  {24'd0, bus.ram_din}, 32'd0);
        check("mid_rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("mid_rst_overflow", {31'd0, bus.overflow}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_writes", exp_q.size(), 32'd0);
        check("mid_rst_no_autorun", autorun_cnt - base, 32'd0);
        check("mid_rst_hold_idle", {31'd0, bus.cpu_hold}, 32'd0);

        // Clean restart after the abandoned patch
        run_load(1'b1, 1'b1, 1'b1, 2, 16'h0600, 8'hE0, 16'h0602, "restart");

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
